seq_alu: RTL and testbench

//   Parametrised, registered ALU with valid/ready handshakes on input and output.

---
 rtl/seq_alu.sv | 155 +++++++++++++++
 tb/tb_seq_alu.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes; div/mod use a WIDTH-cycle restoring divider.
// One op in flight at a time; results and flags hold until the consumer takes them.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_NOT = 3'b100, OP_DIV = 3'b101, OP_MOD = 3'b110, OP_XOR = 3'b111
  } op_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             is_mod_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, ovf_q, zero_q, dbz_q, out_valid_q;

  logic [WIDTH:0]   sum_d, diff_d;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_c_d, alu_v_d, alu_dbz_d, is_divop_d;

  logic [WIDTH:0]   trial_d, sub_d;
  logic             qbit_d;
  logic [WIDTH-1:0] rem_d, quo_d, div_out_d;

  always_comb begin
    sum_d      = {1'b0, a} + {1'b0, b};
    diff_d     = {1'b0, a} - {1'b0, b};
    alu_res_d  = '0;
    alu_c_d    = 1'b0;
    alu_v_d    = 1'b0;
    alu_dbz_d  = 1'b0;
    is_divop_d = (op == OP_DIV) || (op == OP_MOD);
    case (op)
      OP_ADD: begin
        alu_res_d = sum_d[WIDTH-1:0];
        alu_c_d   = sum_d[WIDTH];
        alu_v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        alu_res_d = diff_d[WIDTH-1:0];
        alu_c_d   = diff_d[WIDTH];
        alu_v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_d[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:         alu_res_d = a & b;
      OP_OR:          alu_res_d = a | b;
      OP_NOT:         alu_res_d = ~a;
      OP_XOR:         alu_res_d = a ^ b;
      OP_DIV, OP_MOD: alu_dbz_d = (b == '0);
      default:        alu_res_d = '0;
    endcase
  end

  // Restoring step: dividend bits shift out of quo_q as quotient bits shift in.
  always_comb begin
    trial_d   = {rem_q, quo_q[WIDTH-1]};
    sub_d     = trial_d - {1'b0, dvs_q};
    qbit_d    = (trial_d >= {1'b0, dvs_q});
    rem_d     = qbit_d ? sub_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], qbit_d};
    div_out_d = is_mod_q ? rem_d : quo_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      is_mod_q    <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_divop_d && (b != '0)) begin
              state_q  <= DIV;
              cnt_q    <= CW'(WIDTH);
              rem_q    <= '0;
              quo_q    <= a;
              dvs_q    <= b;
              is_mod_q <= (op == OP_MOD);
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res_d;
              carry_q     <= alu_c_d;
              ovf_q       <= alu_v_d;
              zero_q      <= (alu_res_d == '0);
              dbz_q       <= alu_dbz_d;
            end
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= div_out_d;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= (div_out_d == '0);
            dbz_q       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign carry       = carry_q;
  assign overflow    = ovf_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): expected results queued at issue,
// compared at handoff together with latency, hold-while-stalled and reset-drop behaviour.
module tb_seq_alu;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry, overflow, zero, div_by_zero, busy;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;   // {carry, overflow, zero, div_by_zero}
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top);
    exp_t e;
    int ua, ub, sa, sb_, s;
    logic c, v, dz;
    ua = int'(ta); ub = int'(tb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb_ = (ub >= 128) ? ub - 256 : ub;
    c = 0; v = 0; dz = 0; e.lat = 1; s = 0;
    case (top)
      3'd0: begin s = ua + ub; c = (s > 255); v = ((sa + sb_) > 127) || ((sa + sb_) < -128); end
      3'd1: begin s = ua - ub + 256; c = (ua < ub); v = ((sa - sb_) > 127) || ((sa - sb_) < -128); end
      3'd2: s = ua & ub;
      3'd3: s = ua | ub;
      3'd4: s = 255 - ua;
      3'd5: if (ub == 0) dz = 1; else begin s = ua / ub; e.lat = W + 1; end
      3'd6: if (ub == 0) dz = 1; else begin s = ua % ub; e.lat = W + 1; end
      default: s = ua ^ ub;
    endcase
    e.res   = W'(s % 256);
    e.flags = {c, v, (e.res == 0), dz};
    return e;
  endfunction

  // Monitor: accept timing, latency, hold stability and handoff comparison.
  int   cyc = 0, acc_cyc = 0, lat = 0;
  logic ov_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst && in_valid && in_ready) acc_cyc = cyc;
    if (out_valid && !ov_prev) lat = cyc - acc_cyc;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        check("hold_result", 32'(result), 32'(sb[0].res));
        check("hold_flags", 32'({carry, overflow, zero, div_by_zero}), 32'(sb[0].flags));
        check("in_ready_busy", 32'({in_ready, busy}), 32'b01);
        if (out_ready) begin
          check("latency", 32'(lat), 32'(sb[0].lat));
          void'(sb.pop_front());
        end
      end
    end
    ov_prev = out_valid;
  end

  // All driver activity happens 1 time unit after a rising edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("send_timeout", 32'd0, 32'd1);
    a = ta; b = tb; op = top; in_valid = 1'b1;
    sb.push_back(model(ta, tb, top));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({carry, overflow, zero, div_by_zero}), 32'd0);
    check("rst_hs", 32'({in_ready, out_valid, busy}), 32'b100);
    @(posedge clk); #1;

    // Basic ops on 12, 4 and the arithmetic boundary cases.
    for (int i = 0; i < 8; i++) begin send(8'd12, 8'd4, 3'(i)); drain(); end
    send(8'd13, 8'd4, 3'd6);   drain();
    send(8'd12, 8'd0, 3'd5);   drain();
    send(8'd12, 8'd0, 3'd6);   drain();
    send(8'd200, 8'd100, 3'd0); drain();
    send(8'd100, 8'd50, 3'd0); drain();
    send(8'd4, 8'd12, 3'd1);   drain();
    send(8'd128, 8'd1, 3'd1);  drain();
    send(8'd255, 8'd1, 3'd6);  drain();

    // Consumer stalls for 5 cycles while a new request is offered and must be ignored.
    out_ready = 1'b0;
    send(8'd12, 8'd4, 3'd0);
    repeat (2) begin @(posedge clk); #1; end
    a = 8'd99; b = 8'd1; op = 3'd1; in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset in the 4th divider cycle drops the op.
    send(8'd12, 8'd4, 3'd5);
    repeat (3) begin @(posedge clk); #1; end
    check("mid_div_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    sb.delete();
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_hs", 32'({in_ready, out_valid, busy}), 32'b100);
    check("post_rst_result", 32'(result), 32'd0);
    repeat (12) begin @(posedge clk); #1; end
    send(8'd12, 8'd4, 3'd5); drain();

    // Random mix.
    for (int i = 0; i < 24; i++) begin
      send(W'($urandom_range(0, 255)), W'($urandom_range(0, 15) == 0 ? 0 : $urandom_range(0, 255)),
           3'($urandom_range(0, 7)));
      drain();
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
